// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Command encoding and strobe priority decoder for the pc_ras block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_INC   = 3'd1,
    PC_REL   = 3'd2,
    PC_LOAD  = 3'd3,
    PC_CALL  = 3'd4,
    PC_RET   = 3'd5,
    PC_RESET = 3'd6
  } pc_cmd_e;

  // Only the highest-priority strobe takes effect in a given cycle.
  function automatic pc_cmd_e pc_decode(input logic i_reset, input logic i_ret,
                                        input logic i_call, input logic i_load,
                                        input logic i_rel, input logic i_inc);
    pc_cmd_e v_cmd;
    if (i_reset)     v_cmd = PC_RESET;
    else if (i_ret)  v_cmd = PC_RET;
    else if (i_call) v_cmd = PC_CALL;
    else if (i_load) v_cmd = PC_LOAD;
    else if (i_rel)  v_cmd = PC_REL;
    else if (i_inc)  v_cmd = PC_INC;
    else             v_cmd = PC_HOLD;
    return v_cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_lifo.sv
// ============================================================================
// Module : ras_lifo
// Brief  : Return-address LIFO storage with occupancy counter; the caller
//          guarantees no push when full and no pop when empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ras_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  assign w_wr_idx = r_count[AW-1:0];
  // Clamp so an empty stack never addresses past the array.
  assign w_rd_idx = (r_count == '0) ? '0 : AW'(r_count - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (pop) begin
      r_count <= r_count - CW'(1);
    end else if (push) begin
      r_mem[w_wr_idx] <= wdata;
      r_count         <= r_count + CW'(1);
    end
  end

  assign rdata = r_mem[w_rd_idx];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module : pc_ras
// Brief  : Registered program counter with call/return stack and sticky
//          overflow/underflow flags. Define PC_REL_EN to add the rel port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
`ifdef PC_REL_EN
  input  logic                       rel,
`endif
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp_count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_unf;
  pc_cmd_e          w_cmd;
  logic             w_rel;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_top;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

`ifdef PC_REL_EN
  assign w_rel = rel;
`else
  assign w_rel = 1'b0;
`endif

  assign w_cmd   = pc_decode(reset, ret, call, load, w_rel, inc);
  assign w_full  = (w_count == CW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_push  = (w_cmd == PC_CALL) && !w_full;
  assign w_pop   = (w_cmd == PC_RET)  && !w_empty;

  ras_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (r_out + WIDTH'(1)),
    .rdata (w_top),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    case (w_cmd)
      PC_RESET: begin
        r_out <= '0;
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      PC_RET: begin
        if (w_empty) r_unf <= 1'b1;
        else         r_out <= w_top;
      end
      PC_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        r_out <= in;
        if (w_full) r_ovf <= 1'b1;
      end
      PC_LOAD: r_out <= in;
      PC_REL:  r_out <= r_out + in;
      PC_INC:  r_out <= r_out + WIDTH'(1);
      default: r_out <= r_out;
    endcase
  end

  assign out      = r_out;
  assign sp_count = w_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf_err  = r_ovf;
  assign unf_err  = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_ras.sv
// ============================================================================
// Module : tb_pc_ras
// Brief  : Directed scoreboard bench for pc_ras (WIDTH=16, DEPTH=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_ras;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk = 1'b0;
  logic        t_reset = 1'b0;
  logic [15:0] t_in = '0;
  logic        t_load = 1'b0;
  logic        t_inc = 1'b0;
  logic        t_call = 1'b0;
  logic        t_ret = 1'b0;
`ifdef PC_REL_EN
  logic        t_rel = 1'b0;
`endif
  logic [15:0] d_out;
  logic [3:0]  d_sp;
  logic        d_full, d_empty, d_ovf, d_unf;

  exp_t q_exp[$];
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pc_ras #(.WIDTH(16), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (t_reset),
    .in       (t_in),
    .load     (t_load),
    .inc      (t_inc),
    .call     (t_call),
    .ret      (t_ret),
`ifdef PC_REL_EN
    .rel      (t_rel),
`endif
    .out      (d_out),
    .sp_count (d_sp),
    .full     (d_full),
    .empty    (d_empty),
    .ovf_err  (d_ovf),
    .unf_err  (d_unf)
  );

  // Apply one command for one cycle and queue the expected post-edge state.
  task automatic step(input string name, input logic rs, input logic rt,
                      input logic cl, input logic ld, input logic ic,
                      input logic [15:0] din, input logic [15:0] eo,
                      input int esp, input logic eov, input logic eun);
    exp_t e;
    @(negedge clk);
    t_reset = rs; t_ret = rt; t_call = cl; t_load = ld; t_inc = ic; t_in = din;
    e.out   = eo;
    e.sp    = 4'(esp);
    e.full  = (esp == 8);
    e.empty = (esp == 0);
    e.ovf   = eov;
    e.unf   = eun;
    q_exp.push_back(e);
    if (name.len() == 0) $display("empty step name");
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = {d_out, d_sp, d_full, d_empty, d_ovf, d_unf};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle%0d: actual out=%h sp=%0d full=%b empty=%b ovf=%b unf=%b required out=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                   total, a.out, a.sp, a.full, a.empty, a.ovf, a.unf,
                   e.out, e.sp, e.full, e.empty, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin : stim
    //                rs rt cl ld ic  in        out       sp ovf unf
    step("reset",     1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("inc1",      0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0);
    step("inc2",      0, 0, 0, 0, 1, 16'h0000, 16'h0002, 0, 0, 0);
    step("inc3",      0, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 0, 0);
    step("hold",      0, 0, 0, 0, 0, 16'h1234, 16'h0003, 0, 0, 0);
    step("ldFFFE",    0, 0, 0, 1, 0, 16'hFFFE, 16'hFFFE, 0, 0, 0);
    step("incFFFF",   0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0);
    step("incwrap",   0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    step("ld5",       0, 0, 0, 1, 0, 16'd5,    16'd5,    0, 0, 0);
    step("call100",   0, 0, 1, 0, 0, 16'd100,  16'd100,  1, 0, 0);
    step("call200",   0, 0, 1, 0, 0, 16'd200,  16'd200,  2, 0, 0);
    step("ret101",    0, 1, 0, 0, 0, 16'd0,    16'd101,  1, 0, 0);
    step("ret6",      0, 1, 0, 0, 0, 16'd0,    16'd6,    0, 0, 0);
    // Fill: pushes are 7, 11, 12, ..., 17.
    for (int i = 0; i < 8; i++)
      step("callfill", 0, 0, 1, 0, 0, 16'(10 + i), 16'(10 + i), i + 1, 0, 0);
    step("callovf",   0, 0, 1, 0, 0, 16'd50,   16'd50,   8, 1, 0);
    step("ret17",     0, 1, 0, 0, 0, 16'd0,    16'd17,   7, 1, 0);
    step("ret16",     0, 1, 0, 0, 0, 16'd0,    16'd16,   6, 1, 0);
    step("rstclr",    1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("ld7",       0, 0, 0, 1, 0, 16'd7,    16'd7,    0, 0, 0);
    step("retempty",  0, 1, 0, 0, 0, 16'd99,   16'd7,    0, 0, 1);
    step("ld3",       0, 0, 0, 1, 0, 16'd3,    16'd3,    0, 0, 1);
    step("rstunf",    1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("call20",    0, 0, 1, 0, 0, 16'd20,   16'd20,   1, 0, 0);
    step("rstall",    1, 0, 1, 1, 0, 16'd12345,16'd0,    0, 0, 0);
    step("retafter",  0, 1, 0, 0, 0, 16'd0,    16'd0,    0, 0, 1);
    step("rst2",      1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("ld9",       0, 0, 0, 1, 0, 16'd9,    16'd9,    0, 0, 0);
    step("callprio",  0, 0, 1, 1, 1, 16'd40,   16'd40,   1, 0, 0);
    step("ret10",     0, 1, 0, 0, 0, 16'd0,    16'd10,   0, 0, 0);
    step("ldneg",     0, 0, 0, 1, 1, 16'h8285, 16'h8285, 0, 0, 0);
    step("ldFFFF",    0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("callwrap",  0, 0, 1, 0, 0, 16'd5,    16'd5,    1, 0, 0);
    step("retprio",   0, 1, 1, 1, 1, 16'd77,   16'd0,    0, 0, 0);
    step("idle",      0, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    @(negedge clk);
    t_reset = 0; t_ret = 0; t_call = 0; t_load = 0; t_inc = 0;
    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    while (!(stim_done && q_exp.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL timeout: actual pending=%0d required pending=0", q_exp.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
